// File: rtl/key_onehot_capture.sv
// Key front end: 2-flop sync, debounce, new-press detect, one-hot VALID/ACK handoff.
// Define MULTI_KEY_ERR_EN to reject multi-key presses with an ERR pulse instead of lowest-index-wins.
module key_onehot_capture #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    input  logic       ack,
    output logic [7:0] onehot,
    output logic       valid,
    output logic       ovr,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       cand;
    logic [7:0]       stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [7:0]       rise;
    logic [7:0]       first_bit;
    logic             new_event;

    assign accept    = (s2 == cand) && (cnt == CNT_MAX) && (cand != stable);
    assign rise      = accept ? (cand & ~stable) : 8'h00;
    // Two's-complement trick isolates the lowest set bit.
    assign first_bit = rise & (~rise + 8'd1);

`ifdef MULTI_KEY_ERR_EN
    logic multi;
    assign multi     = (rise & (rise - 8'd1)) != 8'h00;
    assign new_event = (rise != 8'h00) && !multi;
`else
    assign new_event = (rise != 8'h00);
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 8'h00;
            s2     <= 8'h00;
            cand   <= 8'h00;
            stable <= 8'h00;
            cnt    <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // Releases also land here; they simply produce no rise bits.
            if (accept) begin
                stable <= cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            onehot <= 8'h00;
            valid  <= 1'b0;
            ovr    <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            ovr <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
            err <= multi;
`endif
            case (state)
                IDLE: begin
                    if (new_event) begin
                        onehot <= first_bit;
                        valid  <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (new_event && ack) begin
                        onehot <= first_bit;
                    end else if (new_event) begin
                        ovr <= 1'b1;
                    end else if (ack) begin
                        onehot <= 8'h00;
                        valid  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with DB_CYCLES=4; expected codes queued at press time.
module tb_key_onehot_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic       ack;
    logic [7:0] onehot;
    logic       valid;
    logic       ovr;
    logic       err;

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] expQ[$];

    localparam int LATENCY = 7;

    key_onehot_capture #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key),
        .ack    (ack),
        .onehot (onehot),
        .valid  (valid),
        .ovr    (ovr),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] k);
        key = k;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count edges until VALID rises (bounded), then pop the queued code and compare.
    task automatic waitForCode(input string tag, input int expEdges);
        int edges = 0;
        logic [7:0] exp;
        while (valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, edges, expEdges);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        checkOutput({tag, "_code"}, onehot, exp);
        checkOutput({tag, "_valid"}, valid, 1'b1);
    endtask

    task automatic ackAndRelease(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput({tag, "_ack_clear"}, {valid, onehot}, 9'h000);
        applyStimulus(8'h00);
        repeat (10) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 8'h00;
        ack   = 1'b0;
        repeat (3) tick();
        checkOutput("reset_state", {valid, onehot, ovr, err}, 11'h000);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_quiet", {valid, onehot, ovr}, 10'h000);
        end

        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("ack_in_idle", {valid, onehot}, 9'h000);

        // Clean press: nothing before the 7th edge, code on the 7th.
        applyStimulus(8'h04);
        expQ.push_back(8'h04);
        repeat (LATENCY - 1) tick();
        checkOutput("clean_early", valid, 1'b0);
        waitForCode("clean", 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("clean_hold", {valid, onehot}, {1'b1, 8'h04});
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("clean_ack", {valid, onehot}, 9'h000);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("held_no_repeat", valid, 1'b0);
        end
        applyStimulus(8'h00);
        repeat (10) tick();
        checkOutput("release_no_event", {valid, ovr}, 2'b00);

        // Bouncing key never settles long enough until the final edge.
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h10 : 8'h00);
            repeat (2) begin
                tick();
                checkOutput("bounce_quiet", valid, 1'b0);
            end
        end
        applyStimulus(8'h10);
        expQ.push_back(8'h10);
        waitForCode("bounce", LATENCY);
        ackAndRelease("bounce");

        for (int b = 0; b < 8; b++) begin
            applyStimulus(8'h01 << b);
            expQ.push_back(8'h01 << b);
            waitForCode("walk", LATENCY);
            ackAndRelease("walk");
        end

        // Second press while holding an unacknowledged code is dropped.
        applyStimulus(8'h02);
        expQ.push_back(8'h02);
        waitForCode("ovr_first", LATENCY);
        applyStimulus(8'h22);
        repeat (LATENCY - 1) begin
            tick();
            checkOutput("ovr_early", ovr, 1'b0);
        end
        tick();
        checkOutput("ovr_pulse", {valid, onehot, ovr}, {1'b1, 8'h02, 1'b1});
        tick();
        checkOutput("ovr_single", {valid, onehot, ovr}, {1'b1, 8'h02, 1'b0});
        ackAndRelease("ovr");

        // Same, but ACK lands on the accept cycle: new code replaces the old.
        applyStimulus(8'h02);
        expQ.push_back(8'h02);
        waitForCode("swap_first", LATENCY);
        applyStimulus(8'h22);
        expQ.push_back(8'h20);
        repeat (LATENCY - 1) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("swap_no_ovr", ovr, 1'b0);
        checkOutput("swap_code", onehot, expQ.size() > 0 ? expQ.pop_front() : 8'hxx);
        checkOutput("swap_valid", valid, 1'b1);
        tick();
        checkOutput("swap_no_ovr_late", ovr, 1'b0);
        ackAndRelease("swap");

        applyStimulus(8'h28);
`ifdef MULTI_KEY_ERR_EN
        repeat (LATENCY) tick();
        checkOutput("multi_err", {valid, err}, 2'b01);
        tick();
        checkOutput("multi_err_single", {valid, err}, 2'b00);
        applyStimulus(8'h00);
        repeat (10) tick();
`else
        expQ.push_back(8'h08);
        waitForCode("multi", LATENCY);
        checkOutput("multi_no_err", err, 1'b0);
        ackAndRelease("multi");
`endif

        // Asynchronous reset while a code is held, away from any clock edge.
        applyStimulus(8'h01);
        expQ.push_back(8'h01);
        waitForCode("async", LATENCY);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", {valid, onehot}, 9'h000);
        @(negedge clk);
        applyStimulus(8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("post_reset_quiet", {valid, ovr}, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
